// File: rtl/uart_axil_master_if.sv
// AXI4-Lite channel bundle between the byte-stream bridge (master) and the
// system interconnect (slave).
//   AW: axi_awaddr, axi_awvalid (m->s), axi_awready (s->m)
//   W : axi_wdata, axi_wstrb, axi_wvalid (m->s), axi_wready (s->m)
//   B : axi_bresp, axi_bvalid (s->m), axi_bready (m->s)
//   AR: axi_araddr, axi_arvalid (m->s), axi_arready (s->m)
//   R : axi_ardata, axi_rresp, axi_rvalid (s->m), axi_rready (m->s)
interface uart_axil_master_if;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_ardata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;

  modport master (
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
           axi_bready, axi_araddr, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
           axi_arready, axi_ardata, axi_rresp, axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
           axi_bready, axi_araddr, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid,
           axi_arready, axi_ardata, axi_rresp, axi_rvalid
  );
endinterface

// File: rtl/uart_axil_master.sv
// Byte-stream controlled AXI4-Lite initiator (debug / bring-up bridge).
// Parses 'W' (0x57) addr[4] data[4] and 'R' (0x52) addr[4] commands,
// little-endian, issues one AXI4-Lite transaction and returns a status
// byte (plus 4 read-data bytes for reads). Unknown opcodes answer 0xEE.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_byte/rx_valid    command byte stream in; rx_ready accept strobe
//   tx_byte/tx_valid    response byte stream out; tx_ready from consumer
//   busy                high whenever not waiting for an opcode
//   cmd_timeout         one-cycle pulse when a partial command is dropped
//   axi                 AXI4-Lite master channels
module uart_axil_master #(
  parameter int unsigned IDLE_TIMEOUT = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       cmd_timeout,
  uart_axil_master_if.master axi
);

  localparam int unsigned IW = $clog2(IDLE_TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_DATA, ST_WR_AW_W, ST_WR_B, ST_RD_AR, ST_RD_R, ST_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [2:0]    resp_cnt_q, resp_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          arvalid_q, arvalid_d;
  logic          bready_q, bready_d;
  logic          rready_q, rready_d;
  logic          timeout_q, timeout_d;

  logic accept;
  logic tx_fire;

  assign rx_ready    = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign accept      = rx_valid && rx_ready;
  assign tx_fire     = tx_valid_q && tx_ready;
  assign busy        = (state_q != ST_CMD);
  assign tx_byte     = tx_byte_q;
  assign tx_valid    = tx_valid_q;
  assign cmd_timeout = timeout_q;

  assign axi.axi_awaddr  = addr_q;
  assign axi.axi_araddr  = addr_q;
  assign axi.axi_wdata   = wdata_q;
  assign axi.axi_wstrb   = 4'hF;
  assign axi.axi_awvalid = awvalid_q;
  assign axi.axi_wvalid  = wvalid_q;
  assign axi.axi_arvalid = arvalid_q;
  assign axi.axi_bready  = bready_q;
  assign axi.axi_rready  = rready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CMD;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      resp_cnt_q <= '0;
      idle_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      rready_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      idle_q     <= idle_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      bready_q   <= bready_d;
      rready_q   <= rready_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    resp_cnt_d = resp_cnt_q;
    idle_d     = idle_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    bready_d   = bready_q;
    rready_d   = rready_q;
    timeout_d  = 1'b0;

    // A pending 0xEE reply can drain while a new command is being parsed.
    if (state_q != ST_RESP && tx_fire) tx_valid_d = 1'b0;

    unique case (state_q)
      ST_CMD: begin
        if (accept) begin
          byte_cnt_d = '0;
          idle_d     = '0;
          if (rx_byte == 8'h57) begin
            is_wr_d = 1'b1;
            state_d = ST_ADDR;
          end else if (rx_byte == 8'h52) begin
            is_wr_d = 1'b0;
            state_d = ST_ADDR;
          end else begin
            tx_byte_d  = 8'hEE;
            tx_valid_d = 1'b1;
          end
        end
      end

      // Fields shift in from the top so the first byte lands in [7:0].
      // An accepted byte takes priority over an expiring idle count.
      ST_ADDR, ST_DATA: begin
        if (accept) begin
          idle_d     = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == ST_ADDR) addr_d  = {rx_byte, addr_q[31:8]};
          else                    wdata_d = {rx_byte, wdata_q[31:8]};
          if (byte_cnt_q == 2'd3) begin
            if (state_q == ST_DATA) begin
              state_d   = ST_WR_AW_W;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
            end else if (is_wr_q) begin
              state_d = ST_DATA;
            end else begin
              state_d   = ST_RD_AR;
              arvalid_d = 1'b1;
            end
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d   = ST_CMD;
          timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      // The valid registers themselves record which channel is still owed.
      ST_WR_AW_W: begin
        if (awvalid_q && axi.axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end
      end

      ST_WR_B: begin
        if (axi.axi_bvalid) begin
          bready_d   = 1'b0;
          tx_byte_d  = {6'b0, axi.axi_bresp};
          tx_valid_d = 1'b1;
          resp_cnt_d = '0;
          state_d    = ST_RESP;
        end
      end

      ST_RD_AR: begin
        if (axi.axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end

      ST_RD_R: begin
        if (axi.axi_rvalid) begin
          rready_d   = 1'b0;
          rdata_d    = axi.axi_ardata;
          tx_byte_d  = {6'b0, axi.axi_rresp};
          tx_valid_d = 1'b1;
          resp_cnt_d = '0;
          state_d    = ST_RESP;
        end
      end

      ST_RESP: begin
        if (tx_fire) begin
          if (is_wr_q || resp_cnt_q == 3'd4) begin
            tx_valid_d = 1'b0;
            state_d    = ST_CMD;
          end else begin
            resp_cnt_d = resp_cnt_q + 3'd1;
            unique case (resp_cnt_q)
              3'd0:    tx_byte_d = rdata_q[7:0];
              3'd1:    tx_byte_d = rdata_q[15:8];
              3'd2:    tx_byte_d = rdata_q[23:16];
              default: tx_byte_d = rdata_q[31:24];
            endcase
          end
        end
      end

      default: state_d = ST_CMD;
    endcase
  end

endmodule

// File: tb/tb_uart_axil_master.sv
module tb_uart_axil_master;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       cmd_timeout;

  uart_axil_master_if axi();

  uart_axil_master #(.IDLE_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .cmd_timeout(cmd_timeout),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail = 0;

  // slave configuration and observation
  int          aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [31:0] aw_seen = '0, w_seen = '0, ar_seen = '0;
  logic [3:0]  wstrb_seen = '0;
  bit          b_hs = 0, r_hs = 0;
  int          to_cnt = 0, txv_cnt = 0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI4-Lite slave: readies/responses are driven on the falling edge; a
  // handshake is counted when valid and ready are both high there.
  initial begin
    axi.axi_awready = 0; axi.axi_wready = 0; axi.axi_arready = 0;
    axi.axi_bvalid = 0; axi.axi_bresp = 0;
    axi.axi_rvalid = 0; axi.axi_rresp = 0; axi.axi_ardata = 0;
    forever begin
      @(negedge clk);
      if (b_hs) begin
        axi.axi_bvalid = 0; b_hs = 0;
      end else if (!axi.axi_bvalid && aw_cnt > b_cnt && w_cnt > b_cnt) begin
        axi.axi_bvalid = 1; axi.axi_bresp = bresp_cfg;
      end
      if (axi.axi_bvalid && axi.axi_bready) begin b_hs = 1; b_cnt++; end

      if (r_hs) begin
        axi.axi_rvalid = 0; r_hs = 0;
      end else if (!axi.axi_rvalid && ar_cnt > r_cnt) begin
        axi.axi_rvalid = 1; axi.axi_rresp = rresp_cfg; axi.axi_ardata = rdata_cfg;
      end
      if (axi.axi_rvalid && axi.axi_rready) begin r_hs = 1; r_cnt++; end

      if (axi.axi_awvalid && aw_wait == 0) begin
        axi.axi_awready = 1; aw_cnt++; aw_seen = axi.axi_awaddr;
      end else begin
        axi.axi_awready = 0;
        if (axi.axi_awvalid) aw_wait--;
      end
      if (axi.axi_wvalid && w_wait == 0) begin
        axi.axi_wready = 1; w_cnt++; w_seen = axi.axi_wdata; wstrb_seen = axi.axi_wstrb;
      end else begin
        axi.axi_wready = 0;
        if (axi.axi_wvalid) w_wait--;
      end
      if (axi.axi_arvalid && ar_wait == 0) begin
        axi.axi_arready = 1; ar_cnt++; ar_seen = axi.axi_araddr;
      end else begin
        axi.axi_arready = 0;
        if (axi.axi_arvalid) ar_wait--;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmd_timeout) to_cnt++;
    if (tx_valid) txv_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    rx_byte = b;
    rx_valid = 1;
    for (int k = 0; k < 100; k++) begin
      if (rx_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk($sformatf("rx_accept_%02h", b), {39'b0, ok}, 40'd1);
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int unsigned i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int unsigned i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int unsigned i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  // exp holds the response with the first byte in [7:0].
  task automatic recv_bytes(input string tag, input int n, input int stall, input logic [39:0] exp);
    logic [7:0] b;
    bit got;
    bit stable;
    for (int i = 0; i < n; i++) begin
      got = 0;
      for (int k = 0; k < 300; k++) begin
        if (tx_valid === 1'b1) begin got = 1; break; end
        @(negedge clk);
      end
      chk($sformatf("%s_valid%0d", tag, i), {39'b0, got}, 40'd1);
      if (!got) return;
      b = tx_byte;
      stable = 1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (tx_byte !== b || tx_valid !== 1'b1) stable = 0;
      end
      tx_ready = 1;
      @(negedge clk);
      tx_ready = 0;
      chk($sformatf("%s_byte%0d", tag, i), {32'b0, b}, {32'b0, exp[8*i +: 8]});
      if (stall > 0) chk($sformatf("%s_stable%0d", tag, i), {39'b0, stable}, 40'd1);
    end
    chk($sformatf("%s_no_extra", tag), {39'b0, tx_valid}, 40'd0);
  endtask

  int to0, tx0, axi0;

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", {39'b0, rx_ready}, 40'd1);
    chk("rst_tx_busy_to", {29'b0, tx_valid, tx_byte, busy, cmd_timeout}, 40'd0);
    chk("rst_axi_ctl", {35'b0, axi.axi_awvalid, axi.axi_wvalid, axi.axi_arvalid,
                        axi.axi_bready, axi.axi_rready}, 40'd0);
    chk("rst_awaddr", {8'b0, axi.axi_awaddr}, 40'd0);
    chk("rst_araddr", {8'b0, axi.axi_araddr}, 40'd0);
    chk("rst_wdata", {8'b0, axi.axi_wdata}, 40'd0);
    chk("rst_wstrb", {36'b0, axi.axi_wstrb}, 40'hF);
    rst_n = 1;
    @(negedge clk);

    // basic write: 57 10 00 00 80 EF BE AD DE
    send_write(32'h8000_0010, 32'hDEAD_BEEF);
    chk("wr_valids_next_cycle", {38'b0, axi.axi_awvalid, axi.axi_wvalid}, 40'd3);
    chk("wr_busy", {39'b0, busy}, 40'd1);
    recv_bytes("wr", 1, 0, 40'h00);
    chk("wr_aw_cnt", aw_cnt, 1);
    chk("wr_w_cnt", w_cnt, 1);
    chk("wr_b_cnt", b_cnt, 1);
    chk("wr_awaddr", {8'b0, aw_seen}, {8'b0, 32'h8000_0010});
    chk("wr_wdata", {8'b0, w_seen}, {8'b0, 32'hDEAD_BEEF});
    chk("wr_wstrb", {36'b0, wstrb_seen}, 40'hF);

    // basic read: 52 04 00 00 80 -> 00 05 00 00 00
    rdata_cfg = 32'h0000_0005; rresp_cfg = 2'b00;
    send_read(32'h8000_0004);
    chk("rd_arvalid_next_cycle", {39'b0, axi.axi_arvalid}, 40'd1);
    recv_bytes("rd", 5, 0, {32'h0000_0005, 8'h00});
    chk("rd_ar_cnt", ar_cnt, 1);
    chk("rd_r_cnt", r_cnt, 1);
    chk("rd_araddr", {8'b0, ar_seen}, {8'b0, 32'h8000_0004});

    // SLVERR read with 10-cycle tx backpressure on every byte
    rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b10;
    send_read(32'h8000_0008);
    recv_bytes("rd_err", 5, 10, {32'h1234_5678, 8'h02});
    chk("rd_err_r_cnt", r_cnt, 2);

    // AW delayed 5 cycles, W immediate
    aw_wait = 5; w_wait = 0;
    send_write(32'h0000_0100, 32'h0A0B_0C0D);
    chk("skew_aw_both_up", {38'b0, axi.axi_awvalid, axi.axi_wvalid}, 40'd3);
    @(negedge clk);
    chk("skew_aw_w_dropped", {38'b0, axi.axi_awvalid, axi.axi_wvalid}, 40'd2);
    recv_bytes("skew_aw", 1, 0, 40'h00);
    chk("skew_aw_b_cnt", b_cnt, 2);
    chk("skew_aw_aw_cnt", aw_cnt, 2);

    // W delayed 5 cycles, AW immediate
    aw_wait = 0; w_wait = 5;
    send_write(32'h0000_0104, 32'h1111_2222);
    @(negedge clk);
    chk("skew_w_aw_dropped", {38'b0, axi.axi_awvalid, axi.axi_wvalid}, 40'd1);
    recv_bytes("skew_w", 1, 0, 40'h00);
    chk("skew_w_w_cnt", w_cnt, 3);
    chk("skew_w_b_cnt", b_cnt, 3);
    chk("skew_w_wdata", {8'b0, w_seen}, {8'b0, 32'h1111_2222});

    // both handshakes in the same cycle, DECERR response
    w_wait = 0; bresp_cfg = 2'b11;
    send_write(32'h0000_0108, 32'h3333_4444);
    @(negedge clk);
    chk("skew_both_dropped", {38'b0, axi.axi_awvalid, axi.axi_wvalid}, 40'd0);
    recv_bytes("wr_decerr", 1, 0, 40'h03);
    chk("both_counts", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0], 16'b0}, {8'd4, 8'd4, 8'd4, 16'b0});
    bresp_cfg = 2'b00;

    // partial command then idle: exactly one timeout pulse, nothing else
    to0 = to_cnt; tx0 = txv_cnt; axi0 = aw_cnt + w_cnt + ar_cnt;
    send_byte(8'h57); send_byte(8'h11); send_byte(8'h22);
    repeat (20) @(negedge clk);
    chk("to_pulses", to_cnt - to0, 1);
    chk("to_no_tx", txv_cnt - tx0, 0);
    chk("to_no_axi", aw_cnt + w_cnt + ar_cnt - axi0, 0);
    chk("to_back_in_cmd", {38'b0, rx_ready, busy}, 40'd2);

    // unknown opcode
    send_byte(8'h41);
    chk("bad_op_not_busy", {39'b0, busy}, 40'd0);
    recv_bytes("bad_op", 1, 0, 40'hEE);

    // a complete read afterwards
    rdata_cfg = 32'hCAFE_F00D; rresp_cfg = 2'b00;
    send_read(32'h8000_000C);
    recv_bytes("rd_after", 5, 0, {32'hCAFE_F00D, 8'h00});
    chk("rd_after_araddr", {8'b0, ar_seen}, {8'b0, 32'h8000_000C});

    // reset while arvalid is held
    ar_wait = 1000;
    send_read(32'h8000_0020);
    chk("rst_mid_arvalid_up", {39'b0, axi.axi_arvalid}, 40'd1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_arvalid_async", {39'b0, axi.axi_arvalid}, 40'd0);
    ar_wait = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_mid_rx_ready", {38'b0, rx_ready, busy}, 40'd2);
    rdata_cfg = 32'h1122_3344;
    send_read(32'h8000_0024);
    recv_bytes("rd_post_rst", 5, 0, {32'h1122_3344, 8'h00});
    chk("rd_post_rst_araddr", {8'b0, ar_seen}, {8'b0, 32'h8000_0024});

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
